// File: rtl/bk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bk_pkg
// Description : Shared constants and helpers for the pipelined Brent-Kung
//               carry network (default operand width, pipeline depth and a
//               ceil-log2 used to size the prefix tree levels).
// Revision    : 1.0 - initial release
// ============================================================================
package bk_pkg;

    localparam int BK_DEFAULT_WIDTH = 16;
    localparam int BK_PIPE_STAGES   = 3;

    // Number of tree levels needed to span 'value' bits.
    function automatic int bk_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bk_gp_cell.sv
`default_nettype none
// ============================================================================
// Module      : bk_gp_cell
// Description : Brent-Kung black cell. Merges a high group (gh, ph) with the
//               adjacent low group (gl, pl) into one generate/propagate pair.
// Ports       : gh, ph - high group generate/propagate
//               gl, pl - low group generate/propagate
//               g, p   - merged group generate/propagate
// Revision    : 1.0 - initial release
// ============================================================================
module bk_gp_cell (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    assign g = gh | (ph & gl);
    assign p = ph & pl;

endmodule
`default_nettype wire

// File: rtl/bk_prefix_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bk_prefix_pipe
// Description : Three-stage valid/ready pipelined Brent-Kung carry network.
//               Takes per-bit generate/propagate from the half-adder row plus
//               carry-in and produces sum and carry-out.
//                 S1: capture, carry-in folded into bit 0 generate
//                 S2: up-sweep (log2(WIDTH) levels)
//                 S3: down-sweep (log2(WIDTH)-1 levels) and sum
// Ports       : clk, rst           - clock, synchronous active-high reset
//               in_valid/in_ready  - upstream handshake
//               in_g, in_p, in_cin - per-bit generate, propagate, carry-in
//               out_valid/out_ready- downstream handshake
//               out_sum, out_cout  - result and carry-out
//               out_ovf            - signed overflow (only with BK_OVF_EN)
// Options     : BK_OVF_EN - adds the out_ovf port and its logic
// Revision    : 1.0 - initial release
// ============================================================================
module bk_prefix_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH = BK_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_g,
    input  logic [WIDTH-1:0] in_p,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef BK_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int LEVELS = bk_clog2(WIDTH);

    // ---------------------------------------------------------------- handshake
    // A stage loads when it is empty or its successor loads; the chain is
    // combinational back to in_ready (no skid buffer).
    logic w_load1, w_load2, w_load3;
    logic r1_valid, r2_valid;

    assign w_load3  = ~out_valid | out_ready;
    assign w_load2  = ~r2_valid | w_load3;
    assign w_load1  = ~r1_valid | w_load2;
    assign in_ready = w_load1;

    // ---------------------------------------------------------------- S1
    logic [WIDTH-1:0] r1_g, r1_p;
    logic             r1_cin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_g     <= '0;
            r1_p     <= '0;
            r1_cin   <= 1'b0;
        end else begin
            if (w_load1) begin
                r1_valid <= in_valid;
            end
            if (w_load1 && in_valid) begin
                // Carry-in enters the tree as part of bit 0's generate.
                r1_g   <= {in_g[WIDTH-1:1], in_g[0] | (in_p[0] & in_cin)};
                r1_p   <= in_p;
                r1_cin <= in_cin;
            end
        end
    end

    // ---------------------------------------------------------------- up-sweep
    // Level k merges each node ending on a 2^k boundary with the node 2^(k-1)
    // below it; after the last level bit WIDTH-1 holds the full prefix.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_up
        logic [WIDTH-1:0] w_gi, w_pi, w_go, w_po;

        if (k == 1) begin : g_src_first
            assign w_gi = r1_g;
            assign w_pi = r1_p;
        end else begin : g_src_chain
            assign w_gi = g_up[k-1].w_go;
            assign w_pi = g_up[k-1].w_po;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (1 << k)) == 0) begin : g_cell
                bk_gp_cell u_cell (
                    .gh (w_gi[i]),
                    .ph (w_pi[i]),
                    .gl (w_gi[i - (1 << (k - 1))]),
                    .pl (w_pi[i - (1 << (k - 1))]),
                    .g  (w_go[i]),
                    .p  (w_po[i])
                );
            end else begin : g_pass
                assign w_go[i] = w_gi[i];
                assign w_po[i] = w_pi[i];
            end
        end
    end

    // ---------------------------------------------------------------- S2
    logic [WIDTH-1:0] r2_grp_g, r2_grp_p, r2_bit_p;
    logic             r2_cin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_grp_g <= '0;
            r2_grp_p <= '0;
            r2_bit_p <= '0;
            r2_cin   <= 1'b0;
        end else begin
            if (w_load2) begin
                r2_valid <= r1_valid;
            end
            if (w_load2 && r1_valid) begin
                r2_grp_g <= g_up[LEVELS].w_go;
                r2_grp_p <= g_up[LEVELS].w_po;
                r2_bit_p <= r1_p;
                r2_cin   <= r1_cin;
            end
        end
    end

    // ---------------------------------------------------------------- down-sweep
    // Level d uses span 2^k with k = LEVELS-d. Each node is rewritten at most
    // once, so its group propagate is still the one left by the up-sweep.
    for (genvar d = 1; d < LEVELS; d++) begin : g_dn
        localparam int K = LEVELS - d;
        logic [WIDTH-1:0] w_gi, w_go;

        if (d == 1) begin : g_src_first
            assign w_gi = r2_grp_g;
        end else begin : g_src_chain
            assign w_gi = g_dn[d-1].w_go;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i >= (1 << K)) && (((i + 1) % (1 << K)) == (1 << (K - 1)))) begin : g_cell
                logic w_unused_p;
                bk_gp_cell u_cell (
                    .gh (w_gi[i]),
                    .ph (r2_grp_p[i]),
                    .gl (w_gi[i - (1 << (K - 1))]),
                    .pl (r2_grp_p[i - (1 << (K - 1))]),
                    .g  (w_go[i]),
                    .p  (w_unused_p)
                );
            end else begin : g_pass
                assign w_go[i] = w_gi[i];
            end
        end
    end

    // Only the tree positions read group propagate; the rest is kept for
    // visibility of the up-sweep result.
    logic w_unused_grp_p;
    assign w_unused_grp_p = ^r2_grp_p;

    // ---------------------------------------------------------------- sum
    logic [WIDTH-1:0] w_prefix, w_carry, w_sum;
    logic             w_cout;

    assign w_prefix = g_dn[LEVELS-1].w_go;           // w_prefix[i] = G[i:0]
    assign w_carry  = {w_prefix[WIDTH-2:0], r2_cin};
    assign w_sum    = r2_bit_p ^ w_carry;
    assign w_cout   = w_prefix[WIDTH-1];

    // ---------------------------------------------------------------- S3
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
`ifdef BK_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            if (w_load3) begin
                out_valid <= r2_valid;
            end
            if (w_load3 && r2_valid) begin
                out_sum  <= w_sum;
                out_cout <= w_cout;
`ifdef BK_OVF_EN
                out_ovf  <= w_carry[WIDTH-1] ^ w_cout;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bk_prefix_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bk_prefix_pipe
// Description : Self-checking bench for bk_prefix_pipe (WIDTH=16). Directed
//               g/p/cin vectors with hand-computed sums, latency, backpressure
//               and mid-stream reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bk_prefix_pipe;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_g;
    logic [W-1:0] in_p;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef BK_OVF_EN
    logic         out_ovf;
`endif

    bk_prefix_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_g      (in_g),
        .in_p      (in_p),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef BK_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           id;
    } exp_t;

    vec_t vecs [11];
    exp_t exp_q [$];
    exp_t cur_exp;

    int total = 0;
    int bad   = 0;

    logic         held_v;
    logic [W-1:0] held_sum;
    logic         held_cout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input int idx);
        in_g         = vecs[idx].g;
        in_p         = vecs[idx].p;
        in_cin       = vecs[idx].cin;
        cur_exp.sum  = vecs[idx].sum;
        cur_exp.cout = vecs[idx].cout;
        cur_exp.ovf  = vecs[idx].ovf;
        cur_exp.id   = idx;
    endtask

    // Presents one vector and waits (bounded) for it to be accepted; returns
    // 1ns after the accepting edge with in_valid dropped.
    task automatic send(input int idx);
        bit accepted;
        accepted = 1'b0;
        set_inputs(idx);
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check($sformatf("accept_timeout[%0d]", idx), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: records accepted inputs, checks results in order and checks
    // the payload stays put while stalled.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (held_v) begin
                    check("hold_sum", out_sum, held_sum);
                    check("hold_cout", out_cout, held_cout);
                end
                if (out_ready) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check($sformatf("sum[%0d]", e.id), out_sum, e.sum);
                        check($sformatf("cout[%0d]", e.id), out_cout, e.cout);
`ifdef BK_OVF_EN
                        check($sformatf("ovf[%0d]", e.id), out_ovf, e.ovf);
`endif
                    end
                end else begin
                    held_v    = 1'b1;
                    held_sum  = out_sum;
                    held_cout = out_cout;
                end
            end else begin
                held_v = 1'b0;
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    initial begin
        //            g         p         cin   sum       cout  ovf
        vecs[0]  = '{16'h0001, 16'h00FE, 1'b0, 16'h0100, 1'b0, 1'b0}; // 00FF+0001
        vecs[1]  = '{16'h0001, 16'hFFFE, 1'b0, 16'h0000, 1'b1, 1'b0}; // FFFF+0001
        vecs[2]  = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0}; // FFFF+0+1
        vecs[3]  = '{16'h0001, 16'h7FFE, 1'b0, 16'h8000, 1'b0, 1'b1}; // 7FFF+0001
        vecs[4]  = '{16'h0001, 16'h0000, 1'b0, 16'h0002, 1'b0, 1'b0}; // 0001+0001
        vecs[5]  = '{16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1}; // 8000+8000
        vecs[6]  = '{16'h0220, 16'h5115, 1'b0, 16'h5555, 1'b0, 1'b0}; // 1234+4321
        vecs[7]  = '{16'h0204, 16'hB9F9, 1'b1, 16'hBE02, 1'b0, 1'b0}; // ABCD+1234+1
        vecs[8]  = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0}; // FFFF+FFFF+1
        vecs[9]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1, 1'b1}; // 8000+FFFF
        vecs[10] = '{16'h0001, 16'h0001, 1'b0, 16'h0003, 1'b0, 1'b0}; // g&p overlap

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_g      = '0;
        in_p      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        cur_exp   = '{16'h0, 1'b0, 1'b0, -1};
        held_v    = 1'b0;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, 16'h0);
        check("rst_out_cout", out_cout, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef BK_OVF_EN
        check("rst_out_ovf", out_ovf, 1'b0);
`endif

        // ---- latency: result valid after the third edge following acceptance
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        set_inputs(0);
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1", out_valid, 1'b0);
        @(negedge clk);
        check("lat_cycle2", out_valid, 1'b0);
        @(negedge clk);
        check("lat_cycle3", out_valid, 1'b1);

        // ---- table vectors, streamed back to back
        @(posedge clk);
        #1;
        for (int i = 1; i < 11; i++) send(i);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain_table", exp_q.size(), 0);

        // ---- backpressure: 3 accepted, 4th stalls, then 4 results in a row
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(6);
        send(7);
        send(8);
        set_inputs(9);
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("bp_full_in_ready[%0d]", n), in_ready, 1'b0);
            check($sformatf("bp_full_out_valid[%0d]", n), out_valid, 1'b1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1'b1);
        check("bp_burst0", out_valid, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 1; n < 4; n++) begin
            @(negedge clk);
            check($sformatf("bp_burst%0d", n), out_valid, 1'b1);
        end
        @(negedge clk);
        check("bp_after_burst", out_valid, 1'b0);
        check("bp_queue_empty", exp_q.size(), 0);

        // ---- reset with two results in flight
        @(posedge clk);
        #1;
        send(1);
        send(2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_sum", out_sum, 16'h0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check($sformatf("mid_rst_no_stale[%0d]", n), out_valid, 1'b0);
        end

        // ---- operation resumes after reset
        @(posedge clk);
        #1;
        send(3);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain_final", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
